motor_drive_ctrl: RTL and testbench
===================================

MOTOR_DRIVE_CTRL -- requirements
Module: motor_drive_ctrl

Interface
REQ-001 Parameter PWM_W SHALL default to 8; it is the PWM counter and duty width.
REQ-002 Parameter DEAD_CYC SHALL default to 4; it is the brake cycles on direction reversal, legal range >=1.
REQ-003 Parameter ROT_CYC SHALL default to 1000; it is the ROTATE duration in cycles, legal range >=1.
REQ-004 Port clk SHALL be input, 1 bit: the single clock, rising-edge.
REQ-005 Port rst_n SHALL be input, 1 bit: asynchronous, active-low reset.
REQ-006 Port cmd_valid SHALL be input, 1 bit: a command is presented.
REQ-007 Port cmd SHALL be input, 3 bits, encoded 0 STOP, 1 FRONT, 2 LEFT, 3 RIGHT, 4 ROTATE, 5-7 illegal.
REQ-008 Port duty SHALL be input, PWM_W bits: the on-count per PWM period, sampled with cmd.
REQ-009 Port estop SHALL be input, 1 bit: emergency stop, level-sensitive.
REQ-010 Port cmd_ready SHALL be output, 1 bit: a command is accepted when cmd_valid and cmd_ready are both high.
REQ-011 Port S1 and port S2 SHALL each be output, 1 bit: registered bridge direction lines.
REQ-012 Port pwm SHALL be output, 1 bit: registered motor enable chopper.
REQ-013 Port busy SHALL be output, 1 bit: high when the state is not IDLE.
REQ-014 Port err SHALL be output, 1 bit: one-cycle pulse on acceptance of an illegal cmd.

Function
REQ-015 Direction codes SHALL be: STOP {S1,S2}=00, FRONT 11, LEFT 01, RIGHT 10, ROTATE 10.
REQ-016 The FSM SHALL have exactly four states: IDLE, RUN, ROT, DEAD.
REQ-017 cmd_ready SHALL be high in IDLE, RUN and ROT, low in DEAD, and low whenever estop is high.
REQ-018 Accepting FRONT, LEFT or RIGHT in IDLE SHALL go to RUN, latch dir and duty, and drive S1/S2 on the next cycle (latency 1).
REQ-019 Accepting ROTATE in IDLE SHALL go to ROT, load the timer with ROT_CYC-1, and drive S1/S2=10 on the next cycle.
REQ-020 In ROT the timer SHALL decrement every cycle; in the cycle it reads 0 the FSM SHALL go to IDLE, with S1/S2=00 and pwm=0 on the next cycle, and no dead time.
REQ-021 Accepting a command in RUN/ROT with the same direction code as the current one SHALL update duty only and SHALL NOT open a DEAD window; ROTATE re-issued in ROT SHALL reload the timer.
REQ-022 RIGHT accepted in ROT, or ROTATE accepted in RUN-RIGHT, SHALL switch state without a DEAD window (same code 10).
REQ-023 Accepting a different non-zero direction in RUN/ROT SHALL enter DEAD: S1/S2=00 and pwm=0 for exactly DEAD_CYC cycles, then the pending dir/duty/mode are applied in RUN or ROT.
REQ-024 Accepting STOP in any accepting state SHALL go to IDLE, with S1/S2=00 and pwm=0 on the next cycle.
REQ-025 An illegal cmd SHALL be treated as STOP and SHALL pulse err for one cycle after acceptance.
REQ-026 estop high SHALL force IDLE on the next edge from any state, discard any pending command and any concurrently presented command, and hold IDLE while high.
REQ-027 A free-running PWM_W-bit counter SHALL wrap from 2^PWM_W-1 to 0.
REQ-028 pwm SHALL be registered as (state is RUN or ROT) && (counter < duty_q).
REQ-029 duty=0 SHALL give pwm constant 0; duty=2^PWM_W-1 SHALL give pwm low only when counter=max.
REQ-030 A duty change SHALL take effect from the cycle after acceptance, without resetting the PWM counter.
REQ-031 Counters SHALL be sized with $clog2 of their max values and SHALL never wrap during DEAD or ROT.
REQ-032 S1, S2 and pwm SHALL never be driven to a new non-zero direction without passing through 00 when the code changes from one non-zero value to another.

Reset
REQ-033 While rst_n is low, state SHALL be IDLE, all counters 0, duty_q 0, S1=S2=pwm=busy=err=0, and cmd_ready=1.
REQ-034 Reset mid-DEAD or mid-ROT SHALL abandon the operation; after release the block SHALL accept a command on the first edge.

Verification (PWM_W=4, DEAD_CYC=4, ROT_CYC=10)
REQ-035 The bench SHALL check: FRONT with duty=8 from IDLE -> S1S2=11 after 1 cycle; pwm high for 8 of every 16 cycles; busy=1.
REQ-036 The bench SHALL check: FRONT running, then LEFT accepted -> S1S2=00, pwm=0, cmd_ready=0 for 4 cycles, then S1S2=01.
REQ-037 The bench SHALL check: ROTATE duty=15 -> S1S2=10 for exactly 10 cycles, then 00, busy=0, with no DEAD window.
REQ-038 The bench SHALL check: estop asserted during DEAD together with cmd_valid=1 -> IDLE next cycle, pending command dropped, outputs 00.
REQ-039 The bench SHALL check: cmd=6 accepted in RUN -> err high for 1 cycle, S1S2=00, IDLE.
REQ-040 The bench SHALL check: rst_n low mid-ROT (timer at 5), then released -> all outputs 0; RIGHT accepted on the first edge -> S1S2=10 on the next cycle.

Source files
------------

// File: rtl/motor_drive_ctrl.sv
// H-bridge motor drive controller: command handshake, direction FSM with
// dead-time insertion on reversal, timed rotate mode and a PWM enable chopper.
module motor_drive_ctrl #(
    parameter int PWM_W    = 8,
    parameter int DEAD_CYC = 4,
    parameter int ROT_CYC  = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd,
    input  logic [PWM_W-1:0] duty,
    input  logic             estop,
    output logic             cmd_ready,
    output logic             S1,
    output logic             S2,
    output logic             pwm,
    output logic             busy,
    output logic             err
);

    localparam int TMR_W = (ROT_CYC > 1) ? $clog2(ROT_CYC) : 1;
    localparam int DED_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ROT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [DED_W-1:0] DED_LOAD = DED_W'(DEAD_CYC - 1);
    localparam logic [DED_W-1:0] DED_ONE  = DED_W'(1);
    localparam logic [PWM_W-1:0] CNT_ONE  = PWM_W'(1);

    localparam logic [2:0] CMD_ROTATE = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ROT,
        DEAD
    } state_t;

    state_t             state, state_nx;
    logic [1:0]         dir_q, dir_nx;
    logic [PWM_W-1:0]   duty_q, duty_nx;
    logic [PWM_W-1:0]   cnt_q, cnt_nx;
    logic [TMR_W-1:0]   tmr_q, tmr_nx;
    logic [DED_W-1:0]   ded_q, ded_nx;
    logic               pend_rot_q, pend_rot_nx;
    logic [1:0]         pend_dir_q, pend_dir_nx;
    logic [PWM_W-1:0]   pend_duty_q, pend_duty_nx;
    logic               pwm_q, pwm_nx;
    logic               err_q, err_nx;

    logic               accept;
    logic [1:0]         new_dir;
    logic               new_rot;
    logic               illegal;

    // Bridge line code per command; illegal codes map to 00 so they act as STOP.
    function automatic logic [1:0] dir_of(input logic [2:0] c);
        case (c)
            3'd1:       dir_of = 2'b11;
            3'd2:       dir_of = 2'b01;
            3'd3, 3'd4: dir_of = 2'b10;
            default:    dir_of = 2'b00;
        endcase
    endfunction

    assign cmd_ready = (state != DEAD) && !estop;
    assign accept    = cmd_valid && cmd_ready;
    assign new_dir   = dir_of(cmd);
    assign new_rot   = (cmd == CMD_ROTATE);
    assign illegal   = (cmd > CMD_ROTATE);
    assign cnt_nx    = cnt_q + CNT_ONE;

    always_comb begin
        state_nx     = state;
        dir_nx       = dir_q;
        duty_nx      = duty_q;
        tmr_nx       = tmr_q;
        ded_nx       = ded_q;
        pend_rot_nx  = pend_rot_q;
        pend_dir_nx  = pend_dir_q;
        pend_duty_nx = pend_duty_q;
        err_nx       = 1'b0;

        if (estop) begin
            state_nx = IDLE;
            dir_nx   = 2'b00;
            tmr_nx   = '0;
            ded_nx   = '0;
        end else if (accept) begin
            err_nx = illegal;
            if (new_dir == 2'b00) begin
                state_nx = IDLE;
                dir_nx   = 2'b00;
                tmr_nx   = '0;
            end else if (state == IDLE || new_dir == dir_q) begin
                // Same bridge code (or leaving 00): no reversal, so no dead time.
                state_nx = new_rot ? ROT : RUN;
                dir_nx   = new_dir;
                duty_nx  = duty;
                tmr_nx   = new_rot ? TMR_LOAD : '0;
            end else begin
                state_nx     = DEAD;
                dir_nx       = 2'b00;
                ded_nx       = DED_LOAD;
                tmr_nx       = '0;
                pend_rot_nx  = new_rot;
                pend_dir_nx  = new_dir;
                pend_duty_nx = duty;
            end
        end else begin
            case (state)
                ROT: begin
                    if (tmr_q == '0) begin
                        state_nx = IDLE;
                        dir_nx   = 2'b00;
                    end else begin
                        tmr_nx = tmr_q - TMR_ONE;
                    end
                end
                DEAD: begin
                    if (ded_q == '0) begin
                        state_nx = pend_rot_q ? ROT : RUN;
                        dir_nx   = pend_dir_q;
                        duty_nx  = pend_duty_q;
                        tmr_nx   = pend_rot_q ? TMR_LOAD : '0;
                    end else begin
                        ded_nx = ded_q - DED_ONE;
                    end
                end
                default: ;
            endcase
        end

        // pwm is computed from next-cycle values so it stays aligned with the
        // registered state, counter and duty it is derived from.
        pwm_nx = ((state_nx == RUN) || (state_nx == ROT)) && (cnt_nx < duty_nx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dir_q       <= 2'b00;
            duty_q      <= '0;
            cnt_q       <= '0;
            tmr_q       <= '0;
            ded_q       <= '0;
            pend_rot_q  <= 1'b0;
            pend_dir_q  <= 2'b00;
            pend_duty_q <= '0;
            pwm_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_nx;
            dir_q       <= dir_nx;
            duty_q      <= duty_nx;
            cnt_q       <= cnt_nx;
            tmr_q       <= tmr_nx;
            ded_q       <= ded_nx;
            pend_rot_q  <= pend_rot_nx;
            pend_dir_q  <= pend_dir_nx;
            pend_duty_q <= pend_duty_nx;
            pwm_q       <= pwm_nx;
            err_q       <= err_nx;
        end
    end

    assign S1   = dir_q[1];
    assign S2   = dir_q[0];
    assign pwm  = pwm_q;
    assign busy = (state != IDLE);
    assign err  = err_q;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Bench for motor_drive_ctrl: directed scenarios plus random commands, all
// checked every cycle against a cycle-count based behavioural model.
module tb_motor_drive_ctrl;

    localparam int PWM_W    = 4;
    localparam int DEAD_CYC = 4;
    localparam int ROT_CYC  = 10;
    localparam int PERIOD   = 1 << PWM_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [2:0]       cmd = 3'd0;
    logic [PWM_W-1:0] duty = '0;
    logic             estop = 1'b0;
    logic             cmd_ready, S1, S2, pwm, busy, err;

    motor_drive_ctrl #(.PWM_W(PWM_W), .DEAD_CYC(DEAD_CYC), .ROT_CYC(ROT_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .duty(duty),
        .estop(estop), .cmd_ready(cmd_ready), .S1(S1), .S2(S2), .pwm(pwm),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: activity kind (0 idle, 1 running, 2 rotating, 3 dead time),
    // remaining cycles in the timed activities, and the edge count since reset.
    int m_kind, m_dir, m_duty, m_rot_left, m_dead_left, m_edges;
    int p_kind, p_dir, p_duty;
    int m_err;

    function automatic int dir_code(input int c);
        if (c == 1) return 3;
        if (c == 2) return 1;
        if (c == 3 || c == 4) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_kind = 0; m_dir = 0; m_duty = 0; m_rot_left = 0; m_dead_left = 0;
        m_edges = 0; p_kind = 0; p_dir = 0; p_duty = 0; m_err = 0;
    endtask

    task automatic model_edge();
        int nd;
        bit acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc = cmd_valid && (m_kind != 3) && !estop;
        nd  = dir_code(int'(cmd));
        m_err = 0;
        if (estop) begin
            m_kind = 0; m_dir = 0;
        end else if (acc) begin
            m_err = (cmd > 3'd4) ? 1 : 0;
            if (nd == 0) begin
                m_kind = 0; m_dir = 0;
            end else if (m_kind == 0 || nd == m_dir) begin
                m_kind = (cmd == 3'd4) ? 2 : 1;
                m_dir = nd; m_duty = int'(duty);
                if (m_kind == 2) m_rot_left = ROT_CYC;
            end else begin
                p_kind = (cmd == 3'd4) ? 2 : 1; p_dir = nd; p_duty = int'(duty);
                m_kind = 3; m_dir = 0; m_dead_left = DEAD_CYC;
            end
        end else if (m_kind == 2) begin
            m_rot_left--;
            if (m_rot_left == 0) begin m_kind = 0; m_dir = 0; end
        end else if (m_kind == 3) begin
            m_dead_left--;
            if (m_dead_left == 0) begin
                m_kind = p_kind; m_dir = p_dir; m_duty = p_duty;
                if (m_kind == 2) m_rot_left = ROT_CYC;
            end
        end
        m_edges++;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int exp_pwm;
        exp_pwm = ((m_kind == 1 || m_kind == 2) && ((m_edges % PERIOD) < m_duty)) ? 1 : 0;
        chk("s1s2", 8'({S1, S2}), 8'(m_dir));
        chk("pwm", 8'(pwm), 8'(exp_pwm));
        chk("busy", 8'(busy), 8'(m_kind != 0));
        chk("err", 8'(err), 8'(m_err));
        chk("cmd_ready", 8'(cmd_ready), 8'((m_kind != 3) && !estop));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic send(input logic [2:0] c, input logic [PWM_W-1:0] d);
        cmd_valid = 1'b1; cmd = c; duty = d;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n, lows, r;
        model_reset();

        // Reset state
        repeat (3) step();
        chk("rst_ready", 8'(cmd_ready), 8'd1);
        chk("rst_outs", 8'({S1, S2, pwm, busy, err}), 8'd0);
        #2 rst_n = 1'b1;

        // FRONT duty 8: 11 after one cycle, 8 of 16 cycles high
        send(3'd1, 4'd8);
        chk("front_dir", 8'({S1, S2}), 8'd3);
        chk("front_busy", 8'(busy), 8'd1);
        n = 0;
        repeat (PERIOD) begin step(); n += int'(pwm); end
        chk("front_pwm_count", 8'(n), 8'd8);

        // Reversal FRONT -> LEFT opens a DEAD_CYC window
        send(3'd2, 4'd5);
        n = 0;
        repeat (8) begin
            if (!cmd_ready && {S1, S2} == 2'b00 && !pwm) n++;
            step();
        end
        chk("dead_len", 8'(n), 8'(DEAD_CYC));
        chk("left_dir", 8'({S1, S2}), 8'd1);
        send(3'd0, 4'd0);
        chk("stop_busy", 8'(busy), 8'd0);

        // ROTATE duty 15: 10 cycles of 10, no dead window
        send(3'd4, 4'd15);
        n = ({S1, S2} == 2'b10) ? 1 : 0;
        lows = cmd_ready ? 0 : 1;
        repeat (13) begin
            step();
            if ({S1, S2} == 2'b10) n++;
            if (!cmd_ready) lows++;
        end
        chk("rot_len", 8'(n), 8'(ROT_CYC));
        chk("rot_no_dead", 8'(lows), 8'd0);
        chk("rot_end_dir", 8'({S1, S2}), 8'd0);
        chk("rot_end_busy", 8'(busy), 8'd0);

        // estop during DEAD with a command presented
        send(3'd1, 4'd8);
        step();
        send(3'd3, 4'd4);
        estop = 1'b1; cmd_valid = 1'b1; cmd = 3'd2; duty = 4'd9;
        step();
        chk("estop_dir", 8'({S1, S2}), 8'd0);
        chk("estop_busy", 8'(busy), 8'd0);
        estop = 1'b0; cmd_valid = 1'b0;
        repeat (6) step();
        chk("estop_dropped", 8'(busy), 8'd0);

        // Illegal command while running
        send(3'd1, 4'd3);
        step();
        send(3'd6, 4'd0);
        chk("illegal_err", 8'(err), 8'd1);
        chk("illegal_dir", 8'({S1, S2}), 8'd0);
        chk("illegal_busy", 8'(busy), 8'd0);
        step();
        chk("err_pulse_end", 8'(err), 8'd0);

        // Reset mid-ROT with timer at 5, then RIGHT on the first edge
        send(3'd4, 4'd7);
        repeat (4) step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("midrot_rst_outs", 8'({S1, S2, pwm, busy, err}), 8'd0);
        repeat (2) step();
        #2 rst_n = 1'b1;
        send(3'd3, 4'd9);
        chk("post_rst_right", 8'({S1, S2}), 8'd2);
        chk("post_rst_busy", 8'(busy), 8'd1);

        // Random commands, estop and duty values
        for (int i = 0; i < 800; i++) begin
            estop = ($urandom_range(0, 19) == 0);
            cmd_valid = ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 11));
            cmd = (r < 8) ? 3'(r) : 3'(r - 7);
            duty = PWM_W'($urandom);
            step();
        end
        estop = 1'b0; cmd_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
